// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder for pipeline loads/stores.
// One request is accepted at a time. Its response appears a fixed LATENCY cycles later
// and is held until the consumer takes it.
// Build option: define DMEM_BOUNDS_CHECK_EN to reject addresses at or beyond
// 4*DEPTH_WORDS. Without it, the word index wraps modulo DEPTH_WORDS.
//
// Handshake semantics (both channels): a transfer happens on a rising clk edge where
// valid && ready are both high. The request side is ready only in IDLE. The response
// side holds resp_valid/resp_rdata/resp_err stable from the access edge until the
// edge where resp_ready is seen high. No new request is accepted on that same edge.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_mask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // state is kept as a named typed signal so checkers can bind to it directly
  state_t state;
  state_t state_next;

  logic [3:0]    count;
  logic          cap_we;
  logic [AW-1:0] cap_idx;
  logic [1:0]    cap_off;
  logic [31:0]   cap_wdata;
  logic [3:0]    cap_mask;
  logic          cap_oor;

  logic          accept;
  logic          access;
  logic          access_err;
  logic          do_write;
  logic          addr_oor;

  logic [31:0]   mem [DEPTH_WORDS];

`ifdef DMEM_BOUNDS_CHECK_EN
  // Any byte address past the last word of the array is out of range.
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
  assign addr_oor = ({1'b0, req_addr} >= ADDR_LIMIT);
`else
  // The upper address bits deliberately do not take part, so the index aliases.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:AW+2];
  assign addr_oor         = 1'b0;
`endif

  // A store mask must be a byte, an aligned halfword or a full word.
  // It must also match the low address bits.
  function automatic logic store_legal(input logic [3:0] mask, input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (mask)
      4'b0001: ok = (off == 2'b00);
      4'b0010: ok = (off == 2'b01);
      4'b0100: ok = (off == 2'b10);
      4'b1000: ok = (off == 2'b11);
      4'b0011: ok = (off == 2'b00);
      4'b1100: ok = (off == 2'b10);
      4'b1111: ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign accept     = (state == ST_IDLE) && req_valid;
  assign access     = (state == ST_WAIT) && (count == 4'd0);
  assign access_err = cap_oor | (cap_we & ~store_legal(cap_mask, cap_off));
  assign do_write   = access & cap_we & ~access_err;

  // State register; reset returns to IDLE at once, which drops a store still waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: IDLE -> WAIT on accept, WAIT -> RESP at access, RESP -> IDLE on take.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (req_valid)      state_next = ST_WAIT;
      ST_WAIT: if (count == 4'd0)  state_next = ST_RESP;
      ST_RESP: if (resp_ready)     state_next = ST_IDLE;
      default:                     state_next = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded straight from state.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      ST_IDLE: req_ready  = 1'b1;
      ST_RESP: resp_valid = 1'b1;
      default: begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
      end
    endcase
  end

  // Request capture, latency countdown and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= 4'd0;
      cap_we     <= 1'b0;
      cap_idx    <= '0;
      cap_off    <= 2'b00;
      cap_wdata  <= 32'h0;
      cap_mask   <= 4'h0;
      cap_oor    <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        cap_we    <= req_we;
        cap_idx   <= req_addr[AW+1:2];
        cap_off   <= req_addr[1:0];
        cap_wdata <= req_wdata;
        cap_mask  <= req_mask;
        cap_oor   <= addr_oor;
        count     <= 4'(LATENCY - 1);
      end else if ((state == ST_WAIT) && (count != 4'd0)) begin
        count <= count - 4'd1;
      end
      if (access) begin
        resp_err   <= access_err;
        resp_rdata <= (cap_we || access_err) ? 32'h0 : mem[cap_idx];
      end
    end
  end

  // Byte-lane merge into the array at the access edge; reset never clears contents.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (cap_mask[i]) begin
          mem[cap_idx][8*i +: 8] <= cap_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule
